// File: rtl/spi_sram_datapath_pkg.sv
// Shared definitions for the SPI SRAM datapath: phase encodings, default opcodes
// and a small sizing helper.
package spi_sram_datapath_pkg;

   typedef enum logic [1:0] {
      PH_INSTR = 2'd0,
      PH_ADDR  = 2'd1,
      PH_DATA  = 2'd2,
      PH_END   = 2'd3
   } phase_t;

   localparam logic [7:0] OP_WRITE_DEF = 8'h02;
   localparam logic [7:0] OP_READ_DEF  = 8'h03;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_sram_datapath_sram_array.sv
// DATA_W x 2**ADDR_W storage array: synchronous write on SCK, asynchronous read.
// Contents are intentionally not reset.
module sram_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              SCK,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge SCK) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/spi_sram_datapath.sv
// SCK-domain SPI SRAM datapath: phase/bit tracking, instruction/address/data shift
// registers, opcode decode and the storage array, driven by the control FSM's enables.
module spi_sram_datapath
   import spi_sram_datapath_pkg::*;
#(
   parameter int                 INSTR_W  = 8,
   parameter int                 ADDR_W   = 8,
   parameter int                 DATA_W   = 8,
   parameter logic [INSTR_W-1:0] OP_WRITE = INSTR_W'(OP_WRITE_DEF),
   parameter logic [INSTR_W-1:0] OP_READ  = INSTR_W'(OP_READ_DEF)
) (
   input  logic SCK,
   input  logic rst_n,
   input  logic ss,
   input  logic MOSI,
   output logic MISO,
   input  logic count,
   input  logic instrShift,
   input  logic shiftAddr,
   input  logic shiftTX,
   input  logic shiftRX,
   input  logic loadRX,
   input  logic WE,
   output logic done,
   output logic WR,
   output logic err
);

   localparam int MAX_LEN = max3(INSTR_W, ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(MAX_LEN) + 1;

   function automatic logic [CNT_W-1:0] phase_len(input phase_t ph);
      case (ph)
         PH_INSTR: return CNT_W'(INSTR_W);
         PH_ADDR:  return CNT_W'(ADDR_W);
         PH_DATA:  return CNT_W'(DATA_W);
         default:  return '0;
      endcase
   endfunction

   phase_t               r_phase;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [INSTR_W-1:0]   r_instr;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_tx;
   logic [DATA_W-1:0]    r_rx;
   logic                 r_err;

   logic                 w_done;
   logic                 w_any_shift;
   logic                 w_legal;
   logic [DATA_W-1:0]    w_rdata;
   phase_t               w_phase_next;

   // done looks only at registers and count, never at the shift enables the FSM gates with it
   assign w_done      = count & (r_bit_cnt == phase_len(r_phase));
   assign w_any_shift = instrShift | shiftAddr | shiftTX | shiftRX;
   assign w_legal     = (r_instr == OP_WRITE) | (r_instr == OP_READ);

   always_comb begin
      w_phase_next = r_phase;
      case (r_phase)
         PH_INSTR: w_phase_next = PH_ADDR;
         PH_ADDR:  w_phase_next = PH_DATA;
         PH_DATA:  w_phase_next = PH_END;
         default:  w_phase_next = PH_END;
      endcase
   end

   always_ff @(posedge SCK or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= PH_INSTR;
         r_bit_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         // count low means the FSM is idle: recover from any aborted transaction
         if (!count) begin
            r_phase   <= PH_INSTR;
            r_bit_cnt <= '0;
         end else if (w_done) begin
            r_phase   <= w_phase_next;
            r_bit_cnt <= '0;
         end else if (w_any_shift) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
         if (w_done && (r_phase == PH_INSTR)) r_err <= ~w_legal;
      end
   end

   always_ff @(posedge SCK or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_addr  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
      end else begin
         if (instrShift) r_instr <= {r_instr[INSTR_W-2:0], MOSI};
         if (shiftAddr)  r_addr  <= {r_addr[ADDR_W-2:0], MOSI};
         if (shiftTX)    r_tx    <= {r_tx[DATA_W-2:0], MOSI};
         // a load sees the pre-write word when WE fires on the same edge
         if (loadRX)       r_rx <= w_rdata;
         else if (shiftRX) r_rx <= {r_rx[DATA_W-2:0], 1'b0};
      end
   end

   sram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sram_array (
      .SCK   (SCK),
      .we    (WE),
      .waddr (r_addr),
      .wdata (r_tx),
      .raddr (r_addr),
      .rdata (w_rdata)
   );

   assign MISO = r_rx[DATA_W-1] & ~ss;
   assign done = w_done;
   assign WR   = (r_instr == OP_WRITE);
   assign err  = r_err;

endmodule

// File: tb/tb_spi_sram_datapath.sv
// Bench for spi_sram_datapath: plays the control FSM's enable sequence and scoreboards
// read data against a memory model.
module tb_spi_sram_datapath;

   logic SCK = 1'b0;
   logic rst_n = 1'b0;
   logic ss = 1'b1;
   logic MOSI = 1'b0;
   logic count = 1'b0;
   logic instrShift = 1'b0, shiftAddr = 1'b0, shiftTX = 1'b0, shiftRX = 1'b0;
   logic loadRX = 1'b0, WE = 1'b0;
   logic MISO, done, WR, err;

   int checks = 0;
   int errors = 0;
   logic [7:0] mem_model [256];
   logic sb_q [$];

   spi_sram_datapath dut (
      .SCK(SCK), .rst_n(rst_n), .ss(ss), .MOSI(MOSI), .MISO(MISO),
      .count(count), .instrShift(instrShift), .shiftAddr(shiftAddr),
      .shiftTX(shiftTX), .shiftRX(shiftRX), .loadRX(loadRX), .WE(WE),
      .done(done), .WR(WR), .err(err)
   );

   always #5 SCK = ~SCK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // One rising edge with the given enables; entered and left just after a falling edge.
   task automatic clk_edge(input logic ish, input logic sa, input logic stx,
                           input logic srx, input logic lrx, input logic we, input logic mosi);
      instrShift = ish; shiftAddr = sa; shiftTX = stx; shiftRX = srx;
      loadRX = lrx; WE = we; MOSI = mosi;
      @(posedge SCK);
      @(negedge SCK);
      instrShift = 0; shiftAddr = 0; shiftTX = 0; shiftRX = 0;
      loadRX = 0; WE = 0; MOSI = 0;
   endtask

   // kind: 0 instruction, 1 address, 2 write data
   task automatic do_phase(input int kind, input logic [7:0] val);
      for (int i = 7; i >= 0; i--) begin
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_early kind=%0d bit=%0d got=%b exp=0", kind, i, done);
         end
         clk_edge(kind == 0, kind == 1, kind == 2, 1'b0, 1'b0, 1'b0, val[i]);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_missing kind=%0d got=%b exp=1", kind, done);
      end
   endtask

   task automatic read_data();
      logic exp_bit;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL rd_done_early bit=%0d got=%b exp=0", i, done);
         end
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty bit=%0d got=%b exp=<none>", i, MISO);
         end else begin
            exp_bit = sb_q.pop_front();
            if (MISO !== exp_bit) begin
               errors++;
               $display("FAIL miso bit=%0d got=%b exp=%b", i, MISO, exp_bit);
            end
         end
         clk_edge(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rd_done_missing got=%b exp=1", done);
      end
   endtask

   task automatic end_txn();
      ss = 1'b1;
      count = 1'b0;
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL idle_done got=%b exp=0", done);
      end
   endtask

   task automatic transaction(input logic [7:0] op, input logic [7:0] addr,
                              input logic [7:0] data, input logic rbw);
      logic is_wr, exp_err;
      logic [7:0] old_word;
      is_wr   = (op == 8'h02);
      exp_err = !((op == 8'h02) || (op == 8'h03));
      ss = 1'b0;
      count = 1'b1;
      do_phase(0, op);
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (WR !== is_wr) begin
         errors++;
         $display("FAIL wr_decode op=%h got=%b exp=%b", op, WR, is_wr);
      end
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL err_flag op=%h got=%b exp=%b", op, err, exp_err);
      end
      do_phase(1, addr);
      if (is_wr) begin
         clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         do_phase(2, data);
         old_word = mem_model[addr];
         clk_edge(1'b0, 1'b0, 1'b0, 1'b0, rbw, 1'b1, 1'b0);
         mem_model[addr] = data;
         checks++;
         if (done !== 1'b1) begin
            errors++;
            $display("FAIL end_done got=%b exp=1", done);
         end
         if (rbw) begin
            checks++;
            if (MISO !== old_word[7]) begin
               errors++;
               $display("FAIL rbw_msb got=%b exp=%b", MISO, old_word[7]);
            end
         end
      end else begin
         clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         for (int b = 7; b >= 0; b--) sb_q.push_back(mem_model[addr][b]);
         read_data();
         clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      end_txn();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      count = 1'b1;
      @(posedge SCK);
      @(negedge SCK);
      checks++;
      if ({MISO, done, WR, err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0000", {MISO, done, WR, err});
      end
      count = 1'b0;
      rst_n = 1'b1;
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_write();
      transaction(8'h02, 8'h3C, 8'hA5, 1'b0);
   endtask

   task automatic test_read();
      transaction(8'h03, 8'h3C, 8'h00, 1'b0);
   endtask

   task automatic test_reset_midshift();
      ss = 1'b0;
      count = 1'b1;
      // previous read left addr_q = 0x3C, so this stray load puts 0xA5 on MISO
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      clk_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (MISO !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_miso got=%b exp=1", MISO);
      end
      ss = 1'b1;
      #1;
      checks++;
      if (MISO !== 1'b0) begin
         errors++;
         $display("FAIL miso_ss_gate got=%b exp=0", MISO);
      end
      ss = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({MISO, done, WR, err} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset got=%b exp=0000", {MISO, done, WR, err});
      end
      @(negedge SCK);
      rst_n = 1'b1;
      do_phase(0, 8'h02);
      end_txn();
   endtask

   task automatic test_no_crosstalk();
      transaction(8'h02, 8'h3D, 8'hFF, 1'b0);
      transaction(8'h03, 8'h3C, 8'h00, 1'b0);
      transaction(8'h03, 8'h3D, 8'h00, 1'b0);
   endtask

   task automatic test_illegal();
      transaction(8'h7E, 8'h3C, 8'h00, 1'b0);
      transaction(8'h02, 8'h3C, 8'h5A, 1'b1);
      transaction(8'h03, 8'h3C, 8'h00, 1'b0);
   endtask

   task automatic test_abort();
      logic [7:0] addr;
      addr = 8'h10;
      ss = 1'b0;
      count = 1'b1;
      do_phase(0, 8'h02);
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 4; i--)
         clk_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, addr[i]);
      ss = 1'b1;
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_done got=%b exp=0", done);
      end
      end_txn();
      transaction(8'h02, 8'h10, 8'h5A, 1'b0);
      transaction(8'h03, 8'h10, 8'h00, 1'b0);
   endtask

   initial begin
      @(negedge SCK);
      test_reset();
      test_write();
      test_read();
      test_reset_midshift();
      test_no_crosstalk();
      test_illegal();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
